race_counter: RTL and testbench

Transmitter side of the race handshake: counts rising edges of two ring-oscillator outputs in the system clock domain and raises `finished1`/`finished2` when each oscillator reaches a programmed edge count. These flags feed the race arbiter, which resolves which oscillator won. One race runs per `start` pulse. An optional watchdog ends a race in which an oscillator stalls.

---
 rtl/race_counter_if.sv | 32 +++
 rtl/race_counter.sv | 172 +++++++++++++++++
 tb/tb_race_counter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/race_counter_if.sv
// Race-counter signal bundle: race request and oscillator inputs toward the
// counter, finish/busy/timeout flags back toward the arbiter.
interface race_counter_if;
  logic start;
  logic ro1;
  logic ro2;
  logic finished1;
  logic finished2;
  logic busy;
  logic timeout;

  // master drives a race (bench / upstream control), slave is the counter
  modport master (
    output start,
    output ro1,
    output ro2,
    input  finished1,
    input  finished2,
    input  busy,
    input  timeout
  );

  modport slave (
    input  start,
    input  ro1,
    input  ro2,
    output finished1,
    output finished2,
    output busy,
    output timeout
  );
endinterface

// File: rtl/race_counter.sv
// Counts rising edges of two free-running ring oscillators and flags each one
// reaching TARGET. Optional watchdog enabled by macro RACE_TIMEOUT_EN.
module race_counter #(
  parameter int CNT_W   = 16,
  parameter int TARGET  = 1000,
  parameter int TMO_W   = 24,
  parameter int TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  race_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(TARGET);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] ro_raw;
  logic [1:0] fin_q_vec;
  logic [1:0] fin_d_vec;
  logic       in_run;
  logic       start_race;
  logic       both_done;
  logic       expire;

  assign ro_raw     = {bus.ro2, bus.ro1};
  assign in_run     = (state_q == RUN);
  assign start_race = !in_run && bus.start;
  assign both_done  = &fin_d_vec;

  // Reject parameter sets that could make a counter wrap or never finish
  if (TARGET < 1 || (TARGET >> CNT_W) != 0) begin : g_bad_target
    $error("race_counter: TARGET out of range for CNT_W");
  end
  if (TIMEOUT < 1 || (TIMEOUT >> TMO_W) != 0) begin : g_bad_timeout
    $error("race_counter: TIMEOUT out of range for TMO_W");
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic             meta_q;
      logic             sync_q;
      logic             prev_q;
      logic             edge_s;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             fin_q;
      logic             fin_d;

      // Synchronizer and edge register run in every state so a new race
      // starts with settled history.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
          prev_q <= 1'b0;
        end else begin
          meta_q <= ro_raw[gi];
          sync_q <= meta_q;
          prev_q <= sync_q;
        end
      end

      assign edge_s = sync_q & ~prev_q;

      always_comb begin
        cnt_d = cnt_q;
        fin_d = fin_q;
        if (start_race) begin
          cnt_d = '0;
          fin_d = 1'b0;
        end else if (in_run && edge_s && (cnt_q < TARGET_C)) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TARGET_C) begin
            fin_d = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
          fin_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          fin_q <= fin_d;
        end
      end

      assign fin_q_vec[gi] = fin_q;
      assign fin_d_vec[gi] = fin_d;
    end
  endgenerate

`ifdef RACE_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic             timeout_q;
  logic             timeout_d;

  // A finish that completes the pair on the expiry cycle wins over the watchdog
  assign expire = in_run && (tmo_q == TMO_LAST) && !both_done;

  always_comb begin
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    if (start_race) begin
      tmo_d     = '0;
      timeout_d = 1'b0;
    end else if (in_run) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (expire) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (both_done || expire) begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.finished1 = fin_q_vec[0];
  assign bus.finished2 = fin_q_vec[1];
  assign bus.busy      = in_run;

endmodule

// File: tb/tb_race_counter.sv
// Directed scoreboard bench for race_counter with TARGET=4, TIMEOUT=200.
// Expected output changes {finished1,finished2,busy,timeout} are queued with their cycle.
module tb_race_counter;

  logic clk = 1'b0;
  logic rst;

  race_counter_if bus ();

  race_counter #(
    .CNT_W  (16),
    .TARGET (4),
    .TMO_W  (24),
    .TIMEOUT(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] vec;
    int         cyc;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] prev_vec = 4'b0000;
  logic [3:0] mon_v;
  exp_t       mon_e;

  function automatic logic [3:0] outs();
    return {bus.finished1, bus.finished2, bus.busy, bus.timeout};
  endfunction

  // Monitor: every output change must match the next queued expectation
  always @(negedge clk) begin
    mon_v = outs();
    if (mon_v !== prev_vec) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: outputs %b at cycle %0d, required %b unchanged",
                 mon_v, cyc, prev_vec);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_v !== mon_e.vec || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL %s: outputs %b at cycle %0d, required %b at cycle %0d",
                   mon_e.name, mon_v, cyc, mon_e.vec, mon_e.cyc);
        end else begin
          $display("ok   %s: outputs %b at cycle %0d", mon_e.name, mon_v, cyc);
        end
      end
      prev_vec = mon_v;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input logic [3:0] vec, input int at, input string name);
    exp_t e;
    e.vec  = vec;
    e.cyc  = at;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    bus.start = 1'b0;
    bus.ro1   = 1'b0;
    bus.ro2   = 1'b0;
    repeat (4) step();
  endtask

  task automatic check_now(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  int s;

  initial begin
    bus.start = 1'b0;
    bus.ro1   = 1'b0;
    bus.ro2   = 1'b0;
    rst       = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_now("reset_finished1", bus.finished1, 1'b0);
    check_now("reset_finished2", bus.finished2, 1'b0);
    check_now("reset_busy",      bus.busy,      1'b0);
    check_now("reset_timeout",   bus.timeout,   1'b0);
    repeat (3) step();
    rst = 1'b1;
    settle();

    // Race 1: ro1 period 10, ro2 period 14; 4th rises at p=35 and p=49
    s = cyc;
    expect_at(4'b0010, s + 1,  "t1_busy_rise");
    expect_at(4'b1010, s + 38, "t1_finished1");
    expect_at(4'b1100, s + 52, "t1_finished2_busy_fall");
    for (int p = 0; p < 70; p++) begin
      bus.start = (p == 0);
      bus.ro1   = (p % 10) >= 5;
      bus.ro2   = (p % 14) >= 7;
      step();
    end
    settle();

    // Race 2 from HOLD: identical in-phase oscillators, tie on 4th rise at p=21
    s = cyc;
    expect_at(4'b0010, s + 1,  "t2_hold_restart_clears");
    expect_at(4'b1100, s + 24, "t2_tie_finish");
    for (int p = 0; p < 30; p++) begin
      bus.start = (p == 0);
      bus.ro1   = (p % 6) >= 3;
      bus.ro2   = (p % 6) >= 3;
      step();
    end
    settle();

    // Race 3: start pulsed mid-RUN must not restart the counts
    s = cyc;
    expect_at(4'b0010, s + 1,  "t3_busy_rise");
    expect_at(4'b0110, s + 29, "t3_finished2");
    expect_at(4'b1100, s + 31, "t3_finished1_busy_fall");
    for (int p = 0; p < 40; p++) begin
      bus.start = (p == 0) || (p == 15);
      bus.ro1   = (p % 8) >= 4;
      bus.ro2   = ((p + 2) % 8) >= 4;
      step();
    end
    settle();

    // Race 4: reset asserted with cnt1=2, then ro1 keeps toggling with no start
    s = cyc;
    expect_at(4'b0010, s + 1,  "t4_busy_rise");
    expect_at(4'b0000, s + 20, "t4_async_reset");
    for (int p = 0; p < 60; p++) begin
      bus.start = (p == 0);
      bus.ro1   = (p % 10) >= 5;
      bus.ro2   = 1'b0;
      if (p == 20) begin
        rst = 1'b0;
        #1;
        check_now("t4_reset_immediate_busy", bus.busy, 1'b0);
      end
      if (p == 23) rst = 1'b1;
      step();
    end
    settle();

    // Race 5: ro2 stalls low
    s = cyc;
    expect_at(4'b0010, s + 1,  "t5_busy_rise");
    expect_at(4'b1010, s + 38, "t5_finished1");
`ifdef RACE_TIMEOUT_EN
    expect_at(4'b1001, s + 201, "t5_watchdog_expiry");
    for (int p = 0; p < 260; p++) begin
      bus.start = (p == 0);
      bus.ro1   = (p % 10) >= 5;
      bus.ro2   = 1'b0;
      step();
    end
    check_now("t5_timeout_held", bus.timeout, 1'b1);
    check_now("t5_busy_low",     bus.busy,    1'b0);
`else
    for (int p = 0; p < 10000; p++) begin
      bus.start = (p == 0);
      bus.ro1   = (p < 60) && ((p % 10) >= 5);
      bus.ro2   = 1'b0;
      step();
    end
    check_now("t5_busy_held",    bus.busy,    1'b1);
    check_now("t5_timeout_zero", bus.timeout, 1'b0);
`endif

    repeat (3) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: %0d expected changes never seen, required 0 (next %s)",
               exp_q.size(), exp_q[0].name);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
